tqvp_hx2003_pulse_tx_scheduler: RTL and testbench

- Shares one pulse transmitter between NUM_REQ software or hardware requesters.
- Each requester supplies a job descriptor: program end index, loopback index and loop count.
- The block arbitrates round-robin, drives the transmitter's start level and program config, and waits for the frame to finish.
- It then enforces a programmable inter-frame gap and returns a per-requester done/abort pulse. It sits between the peripheral register file and the transmitter core.

---
 rtl/tqvp_hx2003_pulse_tx_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_tqvp_hx2003_pulse_tx_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tqvp_hx2003_pulse_tx_scheduler.sv
// Round-robin scheduler that shares one pulse transmitter between NUM_REQ requesters.
// Optional launch watchdog enabled by defining PULSE_TX_SCHED_WATCHDOG_EN.
module tqvp_hx2003_pulse_tx_scheduler #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned GAP_W   = 16,
    parameter int unsigned WDOG_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [7*NUM_REQ-1:0] req_end_index,
    input  logic [7*NUM_REQ-1:0] req_loopback_index,
    input  logic [8*NUM_REQ-1:0] req_loop_count,
    input  logic [GAP_W-1:0]     gap_cycles,
    input  logic                 tx_valid,
    output logic                 tx_start,
    output logic [6:0]           tx_end_index,
    output logic [6:0]           tx_loopback_index,
    output logic [7:0]           tx_loop_count,
    output logic [NUM_REQ-1:0]   grant,
    output logic [NUM_REQ-1:0]   done,
    output logic [NUM_REQ-1:0]   aborted,
`ifdef PULSE_TX_SCHED_WATCHDOG_EN
    output logic                 wdog_fired,
`endif
    output logic                 busy
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);
`ifdef PULSE_TX_SCHED_WATCHDOG_EN
    localparam bit WdogEn = 1'b1;
`else
    localparam bit WdogEn = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StLaunch, StActive, StGap} state_e;

    state_e              state_q, state_d;
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0]     win_q, win_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;

    logic                tx_start_d, busy_d;
    logic [6:0]          tx_end_index_d, tx_loopback_index_d;
    logic [7:0]          tx_loop_count_d;
    logic [NUM_REQ-1:0]  grant_d, done_d, aborted_d;
`ifdef PULSE_TX_SCHED_WATCHDOG_EN
    logic                wdog_fired_d;
`endif

    logic                found;
    logic [IdxW-1:0]     pick;
    logic                req_win, wdog_expire, complete, abort;
    logic [6:0]          end_arr  [NUM_REQ];
    logic [6:0]          loop_arr [NUM_REQ];
    logic [7:0]          cnt_arr  [NUM_REQ];

    assign req_win     = req[win_q];
    // Counter is dead logic when the watchdog is compiled out.
    assign wdog_expire = WdogEn && (wdog_q == WDOG_W'(1));

    always_comb begin
        for (int j = 0; j < int'(NUM_REQ); j++) begin
            end_arr[j]  = req_end_index[7*j +: 7];
            loop_arr[j] = req_loopback_index[7*j +: 7];
            cnt_arr[j]  = req_loop_count[8*j +: 8];
        end
    end

    // First requester at or above rr_ptr, wrapping.
    always_comb begin
        logic [IdxW:0]   sum;
        logic [IdxW-1:0] idx;
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            sum = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
            if (sum >= (IdxW+1)'(NUM_REQ)) begin
                sum = sum - (IdxW+1)'(NUM_REQ);
            end
            idx = sum[IdxW-1:0];
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q           <= StIdle;
            rr_ptr_q          <= '0;
            win_q             <= '0;
            gap_q             <= '0;
            wdog_q            <= '0;
            tx_start          <= 1'b0;
            tx_end_index      <= '0;
            tx_loopback_index <= '0;
            tx_loop_count     <= '0;
            grant             <= '0;
            done              <= '0;
            aborted           <= '0;
            busy              <= 1'b0;
`ifdef PULSE_TX_SCHED_WATCHDOG_EN
            wdog_fired        <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            rr_ptr_q          <= rr_ptr_d;
            win_q             <= win_d;
            gap_q             <= gap_d;
            wdog_q            <= wdog_d;
            tx_start          <= tx_start_d;
            tx_end_index      <= tx_end_index_d;
            tx_loopback_index <= tx_loopback_index_d;
            tx_loop_count     <= tx_loop_count_d;
            grant             <= grant_d;
            done              <= done_d;
            aborted           <= aborted_d;
            busy              <= busy_d;
`ifdef PULSE_TX_SCHED_WATCHDOG_EN
            wdog_fired        <= wdog_fired_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            StIdle: begin
                if (found) state_d = StLaunch;
            end
            StLaunch: begin
                if (!req_win || (!tx_valid && wdog_expire)) begin
                    abort   = 1'b1;
                    state_d = StGap;
                end else if (tx_valid) begin
                    state_d = StActive;
                end
            end
            StActive: begin
                // A falling valid wins over a dropped request on the same cycle.
                if (!tx_valid) begin
                    complete = 1'b1;
                    state_d  = StGap;
                end else if (!req_win) begin
                    abort   = 1'b1;
                    state_d = StGap;
                end
            end
            StGap: begin
                if (gap_q <= GAP_W'(1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rr_ptr_d            = rr_ptr_q;
        win_d               = win_q;
        gap_d               = gap_q;
        wdog_d              = wdog_q;
        tx_end_index_d      = tx_end_index;
        tx_loopback_index_d = tx_loopback_index;
        tx_loop_count_d     = tx_loop_count;
        grant_d             = grant;
        done_d              = '0;
        aborted_d           = '0;
        tx_start_d          = (state_d == StLaunch) || (state_d == StActive);
        busy_d              = (state_d != StIdle);

        if (state_q == StIdle && found) begin
            win_d               = pick;
            rr_ptr_d            = (32'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
            tx_end_index_d      = end_arr[pick];
            tx_loopback_index_d = loop_arr[pick];
            tx_loop_count_d     = cnt_arr[pick];
            grant_d             = OneHot0 << pick;
            wdog_d              = '1;
        end else if (state_q == StLaunch) begin
            wdog_d = wdog_q - 1'b1;
        end

        if (complete) done_d = OneHot0 << win_q;
        if (abort) aborted_d = OneHot0 << win_q;

        if (complete || abort) begin
            grant_d = '0;
            gap_d   = (gap_cycles == '0) ? GAP_W'(1) : gap_cycles;
        end else if (state_q == StGap) begin
            gap_d = gap_q - 1'b1;
        end

`ifdef PULSE_TX_SCHED_WATCHDOG_EN
        wdog_fired_d = (state_q == StLaunch) && req_win && !tx_valid && wdog_expire;
`endif
    end

endmodule

// File: tb/tb_tqvp_hx2003_pulse_tx_scheduler.sv
// Directed bench for the pulse transmitter scheduler with a simple transmitter model.
module tb_tqvp_hx2003_pulse_tx_scheduler;

    localparam int NR = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req;
    logic [7*NR-1:0] req_end_index;
    logic [7*NR-1:0] req_loopback_index;
    logic [8*NR-1:0] req_loop_count;
    logic [15:0]     gap_cycles;
    logic            tx_valid = 1'b0;
    logic            tx_start;
    logic [6:0]      tx_end_index;
    logic [6:0]      tx_loopback_index;
    logic [7:0]      tx_loop_count;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   done;
    logic [NR-1:0]   aborted;
    logic            busy;
`ifdef PULSE_TX_SCHED_WATCHDOG_EN
    logic            wdog_fired;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tqvp_hx2003_pulse_tx_scheduler #(
        .NUM_REQ(NR),
        .GAP_W  (16),
        .WDOG_W (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .req               (req),
        .req_end_index     (req_end_index),
        .req_loopback_index(req_loopback_index),
        .req_loop_count    (req_loop_count),
        .gap_cycles        (gap_cycles),
        .tx_valid          (tx_valid),
        .tx_start          (tx_start),
        .tx_end_index      (tx_end_index),
        .tx_loopback_index (tx_loopback_index),
        .tx_loop_count     (tx_loop_count),
        .grant             (grant),
        .done              (done),
        .aborted           (aborted),
`ifdef PULSE_TX_SCHED_WATCHDOG_EN
        .wdog_fired        (wdog_fired),
`endif
        .busy              (busy)
    );

    // Transmitter model: valid rises 3 cycles after tx_start rises, stays high valid_len cycles.
    int   tx_cnt     = 0;
    int   valid_len  = 40;
    logic valid_hold = 1'b0;
    always @(posedge clk) begin
        tx_cnt   <= tx_start ? tx_cnt + 1 : 0;
        tx_valid <= !valid_hold && tx_start && (tx_cnt >= 2) && (tx_cnt < 2 + valid_len);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input string tag);
        int k = 0;
        while (grant == '0 && k < 400) begin @(negedge clk); k++; end
        chk(tag, 32'(grant != '0), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done == '0 && k < 400) begin @(negedge clk); k++; end
        chk(tag, 32'(done != '0), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input logic level);
        int k = 0;
        while (tx_valid !== level && k < 400) begin @(negedge clk); k++; end
        chk(tag, 32'(tx_valid), 32'(level));
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 400) begin @(negedge clk); k++; end
        chk(tag, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [NR-1:0] rr_exp [5];
        logic [NR-1:0] g;
        int            start_cycles;
        int            gap_cnt;

        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_n      = 1'b0;
        req        = '0;
        gap_cycles = 16'd4;
        for (int i = 0; i < NR; i++) begin
            req_end_index[7*i +: 7]      = (i == 0) ? 7'd5 : 7'(10 + i);
            req_loopback_index[7*i +: 7] = 7'(20 + i);
            req_loop_count[8*i +: 8]     = (i == 0) ? 8'd2 : 8'(30 + i);
        end
        repeat (2) @(negedge clk);

        chk("rst_tx_start", 32'(tx_start), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_aborted", 32'(aborted), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_end_index", 32'(tx_end_index), 0);
        chk("rst_loop_count", 32'(tx_loop_count), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", 32'(busy), 0);

        // Single job on requester 0.
        req = 4'b0001;
        @(negedge clk);
        chk("single_grant", 32'(grant), 32'b0001);
        chk("single_end_index", 32'(tx_end_index), 5);
        chk("single_loopback", 32'(tx_loopback_index), 20);
        chk("single_loop_count", 32'(tx_loop_count), 2);
        chk("single_tx_start", 32'(tx_start), 1);
        req_end_index[6:0] = 7'd99;
        start_cycles = 1;
        for (int k = 0; k < 200 && done == '0; k++) begin
            @(negedge clk);
            if (tx_start) start_cycles++;
        end
        chk("single_done", 32'(done), 32'b0001);
        chk("single_no_abort", 32'(aborted), 0);
        // 3 cycles to valid + 40 valid + 1 cycle to register the fall.
        chk("single_start_cycles", 32'(start_cycles), 44);
        chk("single_desc_held", 32'(tx_end_index), 5);
        req = '0;
        @(negedge clk);
        chk("single_done_pulse", 32'(done), 0);
        gap_cnt = 1;
        while (busy && gap_cnt < 50) begin @(negedge clk); gap_cnt++; end
        chk("single_gap_len", 32'(gap_cnt), 4);
        req_end_index[6:0] = 7'd5;

        // Round-robin from a fresh reset with everyone requesting.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        gap_cycles = 16'd2;
        req        = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            wait_grant("rr_grant_wait");
            g = grant;
            chk($sformatf("rr_grant%0d", j), 32'(g), 32'(rr_exp[j]));
            wait_done("rr_done_wait");
            chk($sformatf("rr_done%0d", j), 32'(done), 32'(g));
        end
        req = '0;
        wait_idle("rr_idle");

        // Abort: requester 2 withdraws 10 cycles into ACTIVE.
        req = 4'b0100;
        wait_grant("abort_grant_wait");
        chk("abort_grant", 32'(grant), 32'b0100);
        wait_valid("abort_valid_wait", 1'b1);
        repeat (10) @(negedge clk);
        req = '0;
        @(negedge clk);
        chk("abort_pulse", 32'(aborted), 32'b0100);
        chk("abort_no_done", 32'(done), 0);
        chk("abort_tx_start", 32'(tx_start), 0);
        chk("abort_grant_clr", 32'(grant), 0);
        chk("abort_busy_gap", 32'(busy), 1);
        @(negedge clk);
        chk("abort_pulse_end", 32'(aborted), 0);
        wait_idle("abort_idle");

        // Request drop coincides with valid falling: completion wins.
        gap_cycles = 16'd4;
        req = 4'b0010;
        wait_grant("simul_grant_wait");
        chk("simul_grant", 32'(grant), 32'b0010);
        wait_valid("simul_valid_hi", 1'b1);
        wait_valid("simul_valid_lo", 1'b0);
        req = '0;
        @(negedge clk);
        chk("simul_done", 32'(done), 32'b0010);
        chk("simul_no_abort", 32'(aborted), 0);
        wait_idle("simul_idle");

        // Zero gap behaves as a 1-cycle gap.
        gap_cycles = 16'd0;
        valid_len  = 5;
        req = 4'b0001;
        wait_grant("gap0_grant_wait");
        chk("gap0_grant", 32'(grant), 32'b0001);
        wait_done("gap0_done_wait");
        req = '0;
        chk("gap0_start_low", 32'(tx_start), 0);
        chk("gap0_busy_gap", 32'(busy), 1);
        @(negedge clk);
        chk("gap0_idle", 32'(busy), 0);
        chk("gap0_start_still_low", 32'(tx_start), 0);

        // Reset mid-ACTIVE; rr_ptr is 1 here, so the first grant goes to requester 2.
        valid_len  = 40;
        gap_cycles = 16'd2;
        req = 4'b1100;
        wait_grant("rst_grant_wait");
        chk("rstmid_grant", 32'(grant), 32'b0100);
        wait_valid("rstmid_valid", 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_tx_start", 32'(tx_start), 0);
        chk("rstmid_grant_clr", 32'(grant), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_done", 32'(done), 0);
        chk("rstmid_aborted", 32'(aborted), 0);
        chk("rstmid_end_index", 32'(tx_end_index), 0);
        rst_n = 1'b1;
        @(negedge clk);
        // Search restarts at 0, so requester 2 wins again rather than 3.
        chk("rstmid_regrant", 32'(grant), 32'b0100);
        chk("rstmid_regrant_desc", 32'(tx_end_index), 12);
        wait_done("rstmid_done_wait");
        chk("rstmid_done2", 32'(done), 32'b0100);
        req = '0;
        wait_idle("rstmid_idle");

`ifdef PULSE_TX_SCHED_WATCHDOG_EN
        valid_hold = 1'b1;
        req = 4'b0001;
        wait_grant("wdog_grant_wait");
        start_cycles = 1;
        for (int k = 0; k < 400 && aborted == '0; k++) begin
            @(negedge clk);
            if (tx_start) start_cycles++;
        end
        chk("wdog_launch_cycles", 32'(start_cycles), 255);
        chk("wdog_fired", 32'(wdog_fired), 1);
        chk("wdog_aborted", 32'(aborted), 32'b0001);
        chk("wdog_tx_start", 32'(tx_start), 0);
        valid_hold = 1'b0;
        req = '0;
        wait_idle("wdog_idle");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
